// File: rtl/cmp_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_edge_counter
//  Description : Counts rising edges of the analog comparator bit over a
//                programmable gate window of clk cycles.
//                The comparator bit is asynchronous to clk. It passes through a
//                two-flop synchronizer and then a history flop that supplies
//                the edge term. Each finished window latches the result into
//                `count` and `overflow` and pulses `done` for one cycle.
//                `out_byte` presents the latched result one byte at a time.
//
//  Optional    : `CMP_GLITCH_FILTER_EN
//                When defined, a 3-clock persistence filter sits between the
//                synchronizer and the edge detector. This adds 3 cycles of
//                latency and rejects pulses shorter than 3 clocks.
//
//  Parameters  : CNT_W  accumulator / result width (legal 9..16)
//                WIN_W  width of gate_len and of the window down-counter
//
//  Ports       : clk       system clock
//                rst       asynchronous active-high reset
//                ena       design enable; low aborts a running window
//                cmp_in    comparator bit (asynchronous)
//                start     level-sampled measurement request
//                gate_len  window length in clk cycles, sampled on start
//                byte_sel  0 = low result byte, 1 = high result byte
//                busy      window running
//                done      one-cycle pulse when a result is latched
//                overflow  accumulator saturated during the last window
//                count     latched result of the last completed window
//                out_byte  selected result byte (combinational)
//
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_edge_counter #(
   parameter int CNT_W = 16,
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             cmp_in,
   input  logic             start,
   input  logic [WIN_W-1:0] gate_len,
   input  logic             byte_sel,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [CNT_W-1:0] count,
   output logic [7:0]       out_byte
);

   localparam logic [CNT_W-1:0] ACC_MAX = '1;
   localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             s3_q, s3_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Level that feeds the edge detector: the raw synchronized bit, or the
   // filtered version of it when the glitch filter is built in.
   logic             filt_lvl;
   logic             edge_det;
   logic             acc_at_max;
   logic             sat_hit;
   logic [CNT_W-1:0] acc_next;

`ifdef CMP_GLITCH_FILTER_EN
   logic       f_q, f_d;
   logic [1:0] flt_cnt_q, flt_cnt_d;

   // flt_cnt_q counts consecutive clocks during which s2 disagrees with the
   // filtered level. The level follows s2 on the third consecutive one.
   always_comb begin
      f_d       = f_q;
      flt_cnt_d = 2'd0;
      if (s2_q != f_q) begin
         if (flt_cnt_q == 2'd2) begin
            f_d       = s2_q;
            flt_cnt_d = 2'd0;
         end else begin
            flt_cnt_d = flt_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q       <= 1'b0;
         flt_cnt_q <= 2'd0;
      end else begin
         f_q       <= f_d;
         flt_cnt_q <= flt_cnt_d;
      end
   end

   assign filt_lvl = f_q;
`else
   assign filt_lvl = s2_q;
`endif

   // Synchronizer and history flop run in every state.
   always_comb begin
      s1_d = cmp_in;
      s2_d = s1_q;
      s3_d = filt_lvl;
   end

   assign edge_det   = filt_lvl & ~s3_q;
   assign acc_at_max = (acc_q == ACC_MAX);
   // An edge that arrives on a full accumulator is dropped and only
   // recorded as saturation, so the accumulator never wraps.
   assign sat_hit    = edge_det & acc_at_max;
   assign acc_next   = (edge_det && !acc_at_max) ? (acc_q + CNT_W'(1)) : acc_q;

   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      acc_d      = acc_q;
      sat_d      = sat_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      overflow_d = overflow_q;
      count_d    = count_q;

      case (state_q)
         ST_IDLE: begin
            if (start && ena) begin
               if (gate_len != '0) begin
                  // The edge present in this cycle is intentionally dropped.
                  win_d   = gate_len;
                  acc_d   = '0;
                  sat_d   = 1'b0;
                  busy_d  = 1'b1;
                  state_d = ST_COUNT;
               end else begin
                  // A zero-length window completes at once with an empty result.
                  count_d    = '0;
                  overflow_d = 1'b0;
                  done_d     = 1'b1;
               end
            end
         end

         ST_COUNT: begin
            if (!ena) begin
               // Abort: previous result stays visible, and done does not pulse.
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               acc_d = acc_next;
               sat_d = sat_q | sat_hit;
               win_d = win_q - WIN_ONE;
               if (win_q == WIN_ONE) begin
                  // This is the last counted cycle. Its own edge is included.
                  count_d    = acc_next;
                  overflow_d = sat_q | sat_hit;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         win_q      <= '0;
         acc_q      <= '0;
         sat_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         win_q      <= win_d;
         acc_q      <= acc_d;
         sat_q      <= sat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
         count_q    <= count_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign count    = count_q;
   // Shifting by 8 leaves the zero-extended upper part, and the cast keeps
   // its low 8 bits. CNT_W <= 16, so nothing is lost.
   assign out_byte = byte_sel ? 8'(count_q >> 8) : count_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_cmp_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_edge_counter
//  Description : Self-checking bench for cmp_edge_counter (CNT_W = 9).
//                A sample-history reference model derives, clock by clock,
//                whether a rising edge reaches the counter. Each window's
//                expected result is the saturated number of such clocks
//                inside that window.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_edge_counter;

   localparam int CNT_W  = 9;
   localparam int WIN_W  = 16;
   localparam int MAXCNT = (1 << CNT_W) - 1;
   localparam int HSZ    = 16384;
`ifdef CMP_GLITCH_FILTER_EN
   localparam int LAT        = 5;
   localparam int GLITCH_EXP = 0;
`else
   localparam int LAT        = 2;
   localparam int GLITCH_EXP = 2;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ena = 1'b1;
   logic             cmp_in = 1'b0;
   logic             start = 1'b0;
   logic [WIN_W-1:0] gate_len = '0;
   logic             byte_sel = 1'b0;
   logic             busy, done, overflow;
   logic [CNT_W-1:0] count;
   logic [7:0]       out_byte;

   cmp_edge_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .cmp_in(cmp_in), .start(start),
      .gate_len(gate_len), .byte_sel(byte_sel), .busy(busy), .done(done),
      .overflow(overflow), .count(count), .out_byte(out_byte)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 4;
   int win_c0   = 0;

   // hist[k] is the comparator level sampled at clock k.
   // flev[k] is the level seen by the edge detector after clock k.
   // edge_at[k] says whether an edge reaches the accumulator at clock k.
   bit hist    [0:HSZ-1];
   bit flev    [0:HSZ-1];
   bit edge_at [0:HSZ-1];
   bit fm = 1'b0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         for (int i = 0; i < 4; i++) hist[cyc-i] = 1'b0;
         fm         = 1'b0;
         flev[cyc]  = 1'b0;
      end else begin
         hist[cyc] = cmp_in;
`ifdef CMP_GLITCH_FILTER_EN
         // The filtered level follows once three consecutive synchronized
         // samples agree on a new value.
         if (hist[cyc-2] == hist[cyc-3] && hist[cyc-3] == hist[cyc-4] && hist[cyc-2] != fm)
            fm = hist[cyc-2];
         flev[cyc] = fm;
`else
         flev[cyc] = hist[cyc-1];
`endif
      end
      edge_at[cyc] = flev[cyc-1] & ~flev[cyc-2];
   end

   function automatic int model_edges(input int c0, input int n);
      int s = 0;
      for (int k = c0 + 1; k <= c0 + n; k++) s += int'(edge_at[k]);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_window(input int n);
      gate_len = WIN_W'(n);
      start    = 1'b1;
      tick();
      win_c0   = cyc;
      start    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b1; start = 1'b0; cmp_in = 1'b0; byte_sel = 1'b0;
      repeat (3) tick();
      n_checks++; if ({busy, done, overflow} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, overflow}); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
      n_checks++; if (out_byte !== 8'h00) $display("FAIL reset_out_byte: got %h expected 00", out_byte); else n_pass++;
      rst = 1'b0;
      repeat (2) tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_basic();
      int ndone = 0, tdone = -1, expn;
      cmp_in = 1'b0; byte_sel = 1'b0;
      start_window(100);
      n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else n_pass++;
      for (int t = 1; t <= 110; t++) begin
         cmp_in   = (t >= 5) && (((t - 5) % 10) < 5);
         gate_len = WIN_W'($urandom_range(0, 300));
         tick();
         if (done) begin ndone++; if (tdone < 0) tdone = cyc - win_c0; end
      end
      expn = model_edges(win_c0, 100);
      n_checks++; if (ndone != 1) $display("FAIL basic_done_pulses: got %0d expected 1", ndone); else n_pass++;
      n_checks++; if (tdone != 100) $display("FAIL basic_done_time: got %0d expected 100", tdone); else n_pass++;
      n_checks++; if (count !== 9'd10 || int'(count) != expn) $display("FAIL basic_count: got %0d expected 10 (model %0d)", count, expn); else n_pass++;
      n_checks++; if (out_byte !== 8'h0A) $display("FAIL basic_low_byte: got %h expected 0a", out_byte); else n_pass++;
      byte_sel = 1'b1; #1;
      n_checks++; if (out_byte !== 8'h00) $display("FAIL basic_high_byte: got %h expected 00", out_byte); else n_pass++;
      byte_sel = 1'b0;
   endtask

   task automatic test_zero_window();
      cmp_in = 1'b0;
      tick();
      gate_len = '0; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy); else n_pass++;
      n_checks++; if (count !== '0) $display("FAIL zero_count: got %0d expected 0", count); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b expected 0", done); else n_pass++;
   endtask

   task automatic test_saturation();
      int tdone = -1, expn;
      cmp_in = 1'b0;
      repeat (4) tick();
      start_window(2000);
      for (int t = 1; t <= 2010; t++) begin
         cmp_in = ~cmp_in;
         tick();
         if (done && tdone < 0) tdone = cyc - win_c0;
      end
      expn = model_edges(win_c0, 2000);
      n_checks++; if (tdone != 2000) $display("FAIL sat_done_time: got %0d expected 2000", tdone); else n_pass++;
      n_checks++; if (count !== 9'd511 || expn <= MAXCNT) $display("FAIL sat_count: got %0d expected 511 (model edges %0d)", count, expn); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL sat_overflow: got %b expected 1", overflow); else n_pass++;
      byte_sel = 1'b1; #1;
      n_checks++; if (out_byte !== 8'h01) $display("FAIL sat_high_byte: got %h expected 01", out_byte); else n_pass++;
      byte_sel = 1'b0; #1;
      n_checks++; if (out_byte !== 8'hFF) $display("FAIL sat_low_byte: got %h expected ff", out_byte); else n_pass++;
      cmp_in = 1'b0;
      repeat (5) tick();
      start_window(20);
      repeat (22) tick();
      n_checks++; if (count !== '0 || overflow !== 1'b0) $display("FAIL sat_clear: got count=%0d ovf=%b expected 0 0", count, overflow); else n_pass++;
   endtask

   task automatic test_busy_start();
      int ndone = 0, tdone = -1, expn;
      start_window(50);
      for (int t = 1; t <= 60; t++) begin
         start    = (t <= 50) ? 1'($urandom_range(0, 1)) : 1'b0;
         gate_len = WIN_W'($urandom_range(1, 20));
         cmp_in   = 1'($urandom);
         tick();
         if (done) begin ndone++; if (tdone < 0) tdone = cyc - win_c0; end
      end
      start = 1'b0;
      expn  = model_edges(win_c0, 50);
      n_checks++; if (ndone != 1 || tdone != 50) $display("FAIL busy_start_done: got %0d pulses at %0d expected 1 at 50", ndone, tdone); else n_pass++;
      n_checks++; if (int'(count) != expn) $display("FAIL busy_start_count: got %0d expected %0d", count, expn); else n_pass++;
   endtask

   task automatic test_abort();
      int ndone = 0;
      cmp_in = 1'b0;
      repeat (4) tick();
      start_window(70);
      for (int t = 1; t <= 75; t++) begin
         cmp_in = (((t - 1) % 10) < 5);
         tick();
      end
      n_checks++; if (count !== 9'd7 || model_edges(win_c0, 70) != 7) $display("FAIL abort_prior_count: got %0d expected 7", count); else n_pass++;
      start_window(100);
      for (int t = 1; t <= 19; t++) begin cmp_in = ~cmp_in; tick(); end
      ena = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_busy: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
      ena = 1'b1;
      for (int t = 0; t < 110; t++) begin cmp_in = 1'($urandom); tick(); if (done) ndone++; end
      n_checks++; if (ndone != 0 || count !== 9'd7) $display("FAIL abort_result: got %0d pulses count=%0d expected 0 7", ndone, count); else n_pass++;
      ena = 1'b0; gate_len = WIN_W'(5); start = 1'b1;
      for (int t = 0; t < 10; t++) begin tick(); if (done || busy) ndone++; end
      start = 1'b0; ena = 1'b1;
      n_checks++; if (ndone != 0) $display("FAIL ena_low_start: got %0d busy/done cycles expected 0", ndone); else n_pass++;
   endtask

   task automatic test_reset_midwindow();
      start_window(100);
      for (int t = 0; t < 20; t++) begin cmp_in = 1'($urandom); tick(); end
      #3;
      rst = 1'b1;
      #1;
      n_checks++; if ({busy, done, overflow} !== 3'b000 || count !== '0) $display("FAIL midrst_state: got busy=%b done=%b ovf=%b count=%0d expected all 0", busy, done, overflow, count); else n_pass++;
      n_checks++; if (out_byte !== 8'h00) $display("FAIL midrst_low_byte: got %h expected 00", out_byte); else n_pass++;
      byte_sel = 1'b1; #1;
      n_checks++; if (out_byte !== 8'h00) $display("FAIL midrst_high_byte: got %h expected 00", out_byte); else n_pass++;
      byte_sel = 1'b0;
      for (int t = 0; t < 3; t++) begin cmp_in = ~cmp_in; tick(); end
      rst = 1'b0;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0 || count !== '0) $display("FAIL midrst_after: got busy=%b count=%0d expected 0 0", busy, count); else n_pass++;
   endtask

   task automatic test_random();
      for (int w = 0; w < 8; w++) begin
         int n, tdone, expn, expc;
         logic [CNT_W-1:0] ec;
         n = $urandom_range(1, 40); tdone = -1;
         byte_sel = 1'($urandom);
         start_window(n);
         for (int t = 1; t <= n + 3; t++) begin
            cmp_in = 1'($urandom);
            start  = (t <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (done && tdone < 0) tdone = cyc - win_c0;
         end
         start = 1'b0;
         expn = model_edges(win_c0, n);
         expc = (expn > MAXCNT) ? MAXCNT : expn;
         ec   = CNT_W'(expc);
         n_checks++; if (tdone != n) $display("FAIL rand_done_time[%0d]: got %0d expected %0d", w, tdone, n); else n_pass++;
         n_checks++; if (int'(count) != expc || overflow !== (expn > MAXCNT)) $display("FAIL rand_count[%0d]: got %0d/%b expected %0d/%b", w, count, overflow, expc, expn > MAXCNT); else n_pass++;
         n_checks++; if (out_byte !== (byte_sel ? 8'(ec >> 8) : ec[7:0])) $display("FAIL rand_out_byte[%0d]: got %h sel=%b expected count %0d", w, out_byte, byte_sel, expc); else n_pass++;
      end
   endtask

   task automatic test_glitch();
      int expn;
      cmp_in = 1'b0;
      repeat (8) tick();
      start_window(40);
      for (int t = 1; t <= 42; t++) begin
         cmp_in = (t == 5) || (t == 15) || (t == 16);
         tick();
      end
      expn = model_edges(win_c0, 40);
      n_checks++; if (int'(count) != GLITCH_EXP || expn != GLITCH_EXP) $display("FAIL glitch_short_pulses: got %0d expected %0d (model %0d)", count, GLITCH_EXP, expn); else n_pass++;
      for (int g = 0; g < 2; g++) begin
         int n = LAT + 5 - g;
         cmp_in = 1'b0;
         repeat (10) tick();
         start_window(n);
         for (int t = 1; t <= n + 2; t++) begin
            cmp_in = (t >= 5) && (t <= 8);
            tick();
         end
         n_checks++; if (int'(count) != 1 - g || model_edges(win_c0, n) != 1 - g) $display("FAIL glitch_long_pulse[%0d]: got %0d expected %0d", n, count, 1 - g); else n_pass++;
      end
      cmp_in = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_window();
      test_saturation();
      test_busy_start();
      test_abort();
      test_reset_midwindow();
      test_random();
      test_glitch();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
